fetch_unit: RTL and testbench

Parametrised instruction-fetch and next-PC unit for the CPU; it replaces the combinational pcAdder / adder / jAbsConcat / muxPCSrc chain with one registered block. It owns the program counter and issues requests to an instruction memory with variable latency (request/acknowledge). It presents each fetched instruction to the decoder through a valid/ready handshake and applies branch, jump and register-jump redirects at the moment the decoder accepts an instruction. It also detects misaligned targets and counts retired fetches.

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch / next-PC unit: owns the PC, fetches over a req/ack memory port
// and hands instructions to the decoder over valid/ready, applying redirects on accept.
module fetch_unit #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0,
  parameter int                JIMM_BITS = 26
) (
  input  logic                 clk,
  input  logic                 resetN,
  output logic                 imemReq,
  output logic [WIDTH-1:0]     imemAddr,
  input  logic                 imemAck,
  input  logic [31:0]          imemData,
  output logic                 instrValid,
  input  logic                 instrReady,
  output logic [31:0]          instruction,
  output logic [WIDTH-1:0]     instrPc,
  output logic [WIDTH-1:0]     pcPlus4,
  input  logic                 redirectValid,
  input  logic [1:0]           redirectMode,
  input  logic [WIDTH-1:0]     branchOffset,
  input  logic [JIMM_BITS-1:0] jImm,
  input  logic [WIDTH-1:0]     regTarget,
  output logic                 fault,
  output logic [WIDTH-1:0]     instrCount
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] next_pc;

  // Mode 3 (reserved) and an inactive redirect both fall through to sequential flow.
  function automatic logic [WIDTH-1:0] next_pc_f(
    input logic [WIDTH-1:0]     pc4,
    input logic                 rv,
    input logic [1:0]           mode,
    input logic [WIDTH-1:0]     off,
    input logic [JIMM_BITS-1:0] ji,
    input logic [WIDTH-1:0]     rt
  );
    logic [WIDTH-1:0] jfield;
    logic [WIDTH-1:0] hi_mask;
    jfield    = WIDTH'({ji, 2'b00});
    hi_mask   = ~WIDTH'({(JIMM_BITS+2){1'b1}});
    next_pc_f = pc4;
    if (rv) begin
      case (mode)
        2'd0:    next_pc_f = pc4 + (off << 2);
        2'd1:    next_pc_f = (pc4 & hi_mask) | jfield;
        2'd2:    next_pc_f = rt;
        default: next_pc_f = pc4;
      endcase
    end
  endfunction

  always_comb begin
    next_pc    = next_pc_f(pc_plus4_q, redirectValid, redirectMode,
                           branchOffset, jImm, regTarget);
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      REQ: begin
        if (imemAck) begin
          state_d    = HOLD;
          req_d      = 1'b0;
          instr_d    = imemData;
          instr_pc_d = pc_q;
          pc_plus4_d = pc_q + WIDTH'(4);
          valid_d    = 1'b1;
        end
      end
      HOLD: begin
        if (instrReady) begin
          valid_d = 1'b0;
          count_d = count_q + WIDTH'(1);
          // A misaligned target parks the unit without moving the PC.
          if (next_pc[1:0] != 2'b00) begin
            state_d = ERR;
            fault_d = 1'b1;
          end else begin
            state_d = REQ;
            pc_d    = next_pc;
            addr_d  = next_pc;
            req_d   = 1'b1;
          end
        end
      end
      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
      pc_plus4_q <= RESET_PC + WIDTH'(4);
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
    end
  end

  assign imemReq     = req_q;
  assign imemAddr    = addr_q;
  assign instrValid  = valid_q;
  assign instruction = instr_q;
  assign instrPc     = instr_pc_q;
  assign pcPlus4     = pc_plus4_q;
  assign fault       = fault_q;
  assign instrCount  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch/redirect vectors push expected
// addresses and instructions; a negedge monitor compares whatever the DUT presents.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instruction;
  logic [31:0] instrPc;
  logic [31:0] pcPlus4;
  logic        redirectValid;
  logic [1:0]  redirectMode;
  logic [31:0] branchOffset;
  logic [25:0] jImm;
  logic [31:0] regTarget;
  logic        fault;
  logic [31:0] instrCount;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .JIMM_BITS(26)) dut (
    .clk(clk), .resetN(resetN),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instrValid(instrValid), .instrReady(instrReady), .instruction(instruction),
    .instrPc(instrPc), .pcPlus4(pcPlus4),
    .redirectValid(redirectValid), .redirectMode(redirectMode),
    .branchOffset(branchOffset), .jImm(jImm), .regTarget(regTarget),
    .fault(fault), .instrCount(instrCount)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } instr_t;

  instr_t      exp_instr[$];
  logic [31:0] exp_addr[$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          cnt_exp = 0;
  int          ack_delay = 0;
  bit          force_ack = 1'b0;
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Memory model: data word = address ^ 0xDEADBEEF, ack after ack_delay wait cycles.
  initial begin
    imemAck  = 1'b0;
    imemData = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (imemReq === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          imemAck  = 1'b1;
          imemData = imemAddr ^ 32'hDEAD_BEEF;
          wait_cnt = 0;
        end else begin
          imemAck  = 1'b0;
          imemData = 32'h0;
          wait_cnt++;
        end
      end else begin
        imemAck  = force_ack;
        imemData = force_ack ? 32'hBAD0_0000 : 32'h0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (resetN === 1'b1) begin
        if (imemReq === 1'b1) begin
          if (exp_addr.size() == 0) check("unexpected_req", {31'b0, imemReq}, 32'h0);
          else begin
            check("imem_addr", imemAddr, exp_addr[0]);
            if (imemAck === 1'b1) void'(exp_addr.pop_front());
          end
        end
        if (instrValid === 1'b1) begin
          if (exp_instr.size() == 0) check("unexpected_valid", {31'b0, instrValid}, 32'h0);
          else begin
            check("instruction", instruction, exp_instr[0].data);
            check("instr_pc", instrPc, exp_instr[0].pc);
            check("pc_plus4", pcPlus4, exp_instr[0].pc + 32'd4);
            if (instrReady === 1'b1) void'(exp_instr.pop_front());
          end
        end
      end
    end
  end

  task automatic accept(input int gap, input int stall, input int dly, input logic rv,
                        input logic [1:0] md, input logic [31:0] off, input logic [25:0] ji,
                        input logic [31:0] rt, input logic [31:0] nxt, input bit flt);
    int n = 0;
    while (instrValid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (instrValid !== 1'b1) begin
      check("valid_timeout", {31'b0, instrValid}, 32'h1);
      return;
    end
    check("valid_gap", 32'(n), 32'(gap));
    repeat (stall) begin
      redirectValid = 1'b1; redirectMode = 2'd2; regTarget = 32'h3; branchOffset = 32'h7;
      @(posedge clk); #1;
    end
    check("count_before_accept", instrCount, 32'(cnt_exp));
    ack_delay = dly;
    if (!flt) begin
      exp_addr.push_back(nxt);
      exp_instr.push_back('{pc: nxt, data: nxt ^ 32'hDEAD_BEEF});
    end
    instrReady = 1'b1; redirectValid = rv; redirectMode = md;
    branchOffset = off; jImm = ji; regTarget = rt;
    @(posedge clk); #1;
    instrReady = 1'b0; redirectValid = 1'b0; redirectMode = 2'd0;
    branchOffset = 32'h0; jImm = 26'h0; regTarget = 32'h0;
    cnt_exp++;
    check("count_after_accept", instrCount, 32'(cnt_exp));
    check("fault_after_accept", {31'b0, fault}, {31'b0, flt});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    resetN = 1'b0; instrReady = 1'b0; redirectValid = 1'b0; redirectMode = 2'd0;
    branchOffset = 32'h0; jImm = 26'h0; regTarget = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imemReq", {31'b0, imemReq}, 32'h0);
    check("rst_imemAddr", imemAddr, 32'h0);
    check("rst_instrValid", {31'b0, instrValid}, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_instrPc", instrPc, 32'h0);
    check("rst_pcPlus4", pcPlus4, 32'h4);
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_instrCount", instrCount, 32'h0);

    exp_addr.push_back(32'h0);
    exp_instr.push_back('{pc: 32'h0, data: 32'hDEAD_BEEF});
    resetN = 1'b1;
    // gap stall dly rv md offset jImm regTarget next fault
    accept(2, 0, 0, 1'b0, 2'd0, 32'h0,        26'h0,   32'h0,        32'h4,        1'b0);
    accept(1, 0, 0, 1'b0, 2'd0, 32'h0,        26'h0,   32'h0,        32'h8,        1'b0);
    accept(1, 0, 0, 1'b0, 2'd0, 32'h0,        26'h0,   32'h0,        32'hC,        1'b0);
    accept(1, 0, 2, 1'b0, 2'd0, 32'h0,        26'h0,   32'h0,        32'h10,       1'b0);
    check("count_seq", instrCount, 32'd4);
    accept(3, 2, 0, 1'b1, 2'd2, 32'h0,        26'h0,   32'h100,      32'h100,      1'b0);
    accept(1, 0, 0, 1'b1, 2'd0, 32'hFFFF_FFFE, 26'h0,  32'h0,        32'h0FC,      1'b0);
    accept(1, 0, 0, 1'b1, 2'd3, 32'h40,       26'h1,   32'h2000,     32'h100,      1'b0);
    accept(1, 0, 0, 1'b1, 2'd2, 32'h0,        26'h0,   32'h0,        32'h0,        1'b0);
    accept(1, 0, 0, 1'b1, 2'd0, 32'hFFFF_FFFF, 26'h0,  32'h0,        32'h0,        1'b0);
    accept(1, 0, 0, 1'b1, 2'd2, 32'h0,        26'h0,   32'hF000_0010, 32'hF000_0010, 1'b0);
    accept(1, 0, 0, 1'b1, 2'd1, 32'h0,        26'h40,  32'h0,        32'hF000_0100, 1'b0);
    accept(1, 0, 0, 1'b1, 2'd2, 32'h0,        26'h0,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    accept(1, 0, 0, 1'b0, 2'd1, 32'h0,        26'h3FF, 32'h0,        32'h0,        1'b0);
    accept(1, 0, 0, 1'b1, 2'd2, 32'h0,        26'h0,   32'h2000,     32'h2000,     1'b0);
    accept(1, 0, 0, 1'b1, 2'd2, 32'h0,        26'h0,   32'h2002,     32'h0,        1'b1);
    check("err_imemReq", {31'b0, imemReq}, 32'h0);
    check("err_instrValid", {31'b0, instrValid}, 32'h0);
    check("err_pc_held", imemAddr, 32'h2000);
    repeat (4) @(posedge clk);
    #1;
    check("err_fault_sticky", {31'b0, fault}, 32'h1);
    check("err_count", instrCount, 32'd15);

    resetN = 1'b0;
    #1;
    check("rst2_fault", {31'b0, fault}, 32'h0);
    check("rst2_imemAddr", imemAddr, 32'h0);
    check("rst2_instrCount", instrCount, 32'h0);
    cnt_exp = 0;

    // Abort an in-flight request, then offer a stale ack right after release.
    exp_addr.push_back(32'h0);
    ack_delay = 5;
    @(posedge clk); #1;
    resetN = 1'b1;
    n = 0;
    while (imemReq !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("midreq_imemReq", {31'b0, imemReq}, 32'h1);
    @(posedge clk); #1;
    resetN = 1'b0;
    #1;
    check("midreq_rst_imemReq", {31'b0, imemReq}, 32'h0);
    check("midreq_rst_valid", {31'b0, instrValid}, 32'h0);
    exp_addr.delete();
    exp_instr.delete();
    exp_addr.push_back(32'h0);
    exp_instr.push_back('{pc: 32'h0, data: 32'hDEAD_BEEF});
    force_ack = 1'b1;
    ack_delay = 1;
    @(posedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    check("stale_valid", {31'b0, instrValid}, 32'h0);
    accept(2, 0, 0, 1'b0, 2'd0, 32'h0, 26'h0, 32'h0, 32'h4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
